fft_8_frame_ctrl: RTL

Frame sequencer in front of the 8-point FFT core (start/done handshake, parallel 8-element real/imag I/O). Collects 8 serial complex samples from a valid/ready stream and drives the buffered frame to the core. Pulses start, waits for done under a watchdog, captures the results, then streams them out serially. The core runs one frame at a time; the controller owns its start and its parallel buses.

---
 rtl/fft_ctrl_pkg.sv | 21 ++
 rtl/fft_ctrl_watchdog.sv | 31 +++
 rtl/fft_8_frame_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fft_ctrl_pkg.sv
// Shared types and helpers for the 8-point FFT frame controller.
// Optional build macro FFT_CTRL_BITREV_EN selects bit-reversed unload order (see top).
package fft_ctrl_pkg;

  localparam int N_PTS      = 8;
  localparam int IDX_W      = 3;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    START  = 2'd1,
    WAIT   = 2'd2,
    UNLOAD = 2'd3
  } state_t;

  // Mirrors the 3-bit index, mapping bit-reversed core order back to natural order.
  function automatic logic [IDX_W-1:0] bitrev3(input logic [IDX_W-1:0] idx);
    return {idx[0], idx[1], idx[2]};
  endfunction

endpackage

// File: rtl/fft_ctrl_watchdog.sv
// Cycle counter that runs while enabled and flags expiry on its last count.
// Cleared synchronously whenever the controller is outside the wait phase.
module fft_ctrl_watchdog #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count;

  // Saturates at the last count so a held enable cannot wrap back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = en && (count == LAST_CNT);

endmodule

// File: rtl/fft_8_frame_ctrl.sv
// Frame sequencer for an 8-point FFT core: serial load, start/done handshake, serial unload.
// Define FFT_CTRL_BITREV_EN to unload bit-reversed core results in natural order.
module fft_8_frame_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_W-1:0]       s_real,
  input  logic [DATA_W-1:0]       s_imag,
  input  logic                    s_last,
  output logic                    fft_start,
  output logic [N_PTS*DATA_W-1:0] fft_in_real,
  output logic [N_PTS*DATA_W-1:0] fft_in_imag,
  input  logic                    fft_done,
  input  logic [N_PTS*DATA_W-1:0] fft_out_real,
  input  logic [N_PTS*DATA_W-1:0] fft_out_imag,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_W-1:0]       m_real,
  output logic [DATA_W-1:0]       m_imag,
  output logic [IDX_W-1:0]        m_idx,
  output logic                    m_last,
  output logic                    busy,
  output logic                    err_timeout,
  output logic                    err_frame
);

  localparam int BUS_W = N_PTS * DATA_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PTS - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] wr_ptr, rd_ptr, rd_sel;
  logic [BUS_W-1:0] ibuf_real, ibuf_imag, obuf_real, obuf_imag;
  logic             accept, frame_full, wd_expired;

  assign s_ready    = rst_n && (state == LOAD);
  assign accept     = s_valid && s_ready;
  assign frame_full = accept && (wr_ptr == LAST_IDX);
  // s_last must coincide with the eighth sample; a mismatch either way is flagged.
  assign err_frame  = accept && (s_last != (wr_ptr == LAST_IDX));

  fft_ctrl_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state != WAIT),
    .en     (state == WAIT),
    .expired(wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // A done seen in the same cycle as expiry takes priority over the abort.
  always_comb begin
    state_nxt   = state;
    fft_start   = 1'b0;
    busy        = 1'b1;
    m_valid     = 1'b0;
    err_timeout = 1'b0;
    case (state)
      LOAD: begin
        busy = 1'b0;
        if (frame_full) state_nxt = START;
      end
      START: begin
        fft_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (fft_done) begin
          state_nxt = UNLOAD;
        end else if (wd_expired) begin
          err_timeout = 1'b1;
          state_nxt   = LOAD;
        end
      end
      UNLOAD: begin
        m_valid = 1'b1;
        if (m_ready && (rd_ptr == LAST_IDX)) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // A misaligned s_last restarts the frame from slot 0; stale slots are overwritten later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ibuf_real <= '0;
      ibuf_imag <= '0;
      obuf_real <= '0;
      obuf_imag <= '0;
    end else begin
      if (accept) begin
        ibuf_real[wr_ptr*DATA_W +: DATA_W] <= s_real;
        ibuf_imag[wr_ptr*DATA_W +: DATA_W] <= s_imag;
        if (s_last && (wr_ptr != LAST_IDX)) begin
          wr_ptr <= '0;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
      if ((state == WAIT) && fft_done) begin
        obuf_real <= fft_out_real;
        obuf_imag <= fft_out_imag;
        rd_ptr    <= '0;
      end else if ((state == UNLOAD) && m_ready) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

`ifdef FFT_CTRL_BITREV_EN
  assign rd_sel = bitrev3(rd_ptr);
`else
  assign rd_sel = rd_ptr;
`endif

  assign fft_in_real = ibuf_real;
  assign fft_in_imag = ibuf_imag;
  assign m_real      = obuf_real[rd_sel*DATA_W +: DATA_W];
  assign m_imag      = obuf_imag[rd_sel*DATA_W +: DATA_W];
  assign m_idx       = rd_sel;
  assign m_last      = (state == UNLOAD) && (rd_ptr == LAST_IDX);

endmodule
